// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: default sizes and the
// FSM state encoding used by the arbiter core.
package uart_pkg;

   // Default byte width of the transmitter data path.
   localparam int UART_WIDTH   = 8;

   // Default number of requesters sharing one UART transmitter.
   localparam int UART_NUM_REQ = 4;

   // Arbiter FSM states.
   //   IDLE      : free to accept a new request.
   //   WAIT_BUSY : byte launched, waiting for the transmitter to raise busy.
   //   WAIT_DONE : transmitter busy, waiting for it to finish.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side signals of the UART TX
// arbiter. The slave modport is the arbiter's view; the master modport is
// the view of whatever drives the requests and the transmitter busy flag.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int NUM_REQ = UART_NUM_REQ,
   parameter int WIDTH   = UART_WIDTH
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       i_req;
   logic [NUM_REQ*WIDTH-1:0] i_data;
   logic [NUM_REQ-1:0]       i_last;
   logic [NUM_REQ-1:0]       o_gnt;
   logic [IDX_W-1:0]         o_owner;
   logic                     o_tx_data_valid;
   logic [WIDTH-1:0]         o_tx_data;
   logic                     i_tx_busy;
   logic                     o_active;
   logic                     o_err;

   modport master (
      output i_req, i_data, i_last, i_tx_busy,
      input  o_gnt, o_owner, o_tx_data_valid, o_tx_data, o_active, o_err
   );

   modport slave (
      input  i_req, i_data, i_last, i_tx_busy,
      output o_gnt, o_owner, o_tx_data_valid, o_tx_data, o_active, o_err
   );

endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: starting just after the pointer and
// wrapping around, returns the first set request as one-hot and as index.
module uart_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [IDX_W-1:0] cand;

   // Walk ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the pointer itself is last.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // a variable unassigned, which would otherwise infer a latch.
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (!any && req[cand]) begin
            any       = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// requesters. One byte is launched per grant; the next grant waits until
// the transmitter has raised and dropped busy, or until the busy timeout.
// Optional feature: define UART_TX_ARB_LOCK_EN to keep the grant on one
// requester until it sends a byte flagged with i_last (packet lock).
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = UART_NUM_REQ,
   parameter int WIDTH   = UART_WIDTH,
   parameter int BUSY_TO = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(BUSY_TO + 1);

   state_e               state_q;
   logic [IDX_W-1:0]     rr_ptr_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [NUM_REQ-1:0]   gnt_q;
   logic [IDX_W-1:0]     owner_q;
   logic                 valid_q;
   logic [WIDTH-1:0]     data_q;
   logic                 active_q;
   logic                 err_q;

   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   pick_gnt;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic [WIDTH-1:0]     pick_data;
   logic                 launch;

`ifdef UART_TX_ARB_LOCK_EN
   logic lock_q;

   // While locked only the current owner may be granted; the pointer equals
   // the owner after any grant, so it names the locked requester.
   always_comb begin
      eligible = bus.i_req;
      if (lock_q) begin
         eligible = bus.i_req & (NUM_REQ'(1) << rr_ptr_q);
      end
   end

   // Lock follows the i_last flag of each granted byte.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         lock_q <= 1'b0;
      end else if (launch) begin
         lock_q <= ~bus.i_last[pick_idx];
      end
   end
`else
   logic unused_last;

   assign eligible    = bus.i_req;
   assign unused_last = ^bus.i_last;
`endif

   uart_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req (eligible),
      .ptr (rr_ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Byte of the winning requester.
   always_comb begin
      pick_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_idx == IDX_W'(k)) begin
            pick_data = bus.i_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // A request is only accepted when idle and the transmitter is free.
   assign launch = (state_q == IDLE) && !bus.i_tx_busy && pick_any;

   // Arbiter FSM with registered outputs.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= IDX_W'(NUM_REQ - 1);
         cnt_q    <= '0;
         gnt_q    <= '0;
         owner_q  <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         active_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every
         // register samples the pre-edge values, independent of statement
         // order; the pulse outputs default low and are raised below.
         gnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (launch) begin
                  state_q  <= WAIT_BUSY;
                  rr_ptr_q <= pick_idx;
                  owner_q  <= pick_idx;
                  gnt_q    <= pick_gnt;
                  valid_q  <= 1'b1;
                  data_q   <= pick_data;
                  active_q <= 1'b1;
                  cnt_q    <= '0;
               end
            end
            WAIT_BUSY: begin
               if (bus.i_tx_busy) begin
                  state_q <= WAIT_DONE;
               end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
                  state_q  <= IDLE;
                  active_q <= 1'b0;
                  err_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               if (!bus.i_tx_busy) begin
                  state_q  <= IDLE;
                  active_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= IDLE;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_gnt           = gnt_q;
   assign bus.o_owner         = owner_q;
   assign bus.o_tx_data_valid = valid_q;
   assign bus.o_tx_data       = data_q;
   assign bus.o_active        = active_q;
   assign bus.o_err           = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, WIDTH=8,
// BUSY_TO=4). The transmitter busy flag is driven by the bench.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
   localparam int BUSY_TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ (NUM_REQ),
      .WIDTH   (WIDTH),
      .BUSY_TO (BUSY_TO)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_byte(input int k, input logic [7:0] val);
      bus.i_data[k*WIDTH +: WIDTH] = val;
   endtask

   // One transmitter frame: busy high for one cycle, then low back to IDLE.
   task automatic busy_cycle();
      bus.i_tx_busy = 1'b1;
      tick();
      bus.i_tx_busy = 1'b0;
      tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_gnt"},    32'(bus.o_gnt), 32'h0);
      check({tag, "_valid"},  32'(bus.o_tx_data_valid), 32'h0);
      check({tag, "_data"},   32'(bus.o_tx_data), 32'h0);
      check({tag, "_owner"},  32'(bus.o_owner), 32'h0);
      check({tag, "_active"}, 32'(bus.o_active), 32'h0);
      check({tag, "_err"},    32'(bus.o_err), 32'h0);
   endtask

   task automatic wait_gnt(input string tag, output logic [3:0] g);
      logic seen;
      seen = 1'b0;
      g    = '0;
      for (int c = 0; c < 12 && !seen; c++) begin
         tick();
         if (bus.o_gnt != '0) begin
            seen = 1'b1;
            g    = bus.o_gnt;
         end
      end
      check({tag, "_seen"}, 32'(seen), 32'h1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] g;
      int         bad;

      bus.i_req     = '0;
      bus.i_data    = '0;
      bus.i_last    = '0;
      bus.i_tx_busy = 1'b0;

      // Reset state
      #2 rst = 1'b0;
      tick();
      tick();
      check_idle_outputs("reset");
      rst = 1'b1;

      // Single request from requester 2
      set_byte(2, 8'hA5);
      bus.i_req = 4'b0100;
      tick();
      check("single_gnt",    32'(bus.o_gnt), 32'h4);
      check("single_data",   32'(bus.o_tx_data), 32'hA5);
      check("single_valid",  32'(bus.o_tx_data_valid), 32'h1);
      check("single_owner",  32'(bus.o_owner), 32'h2);
      check("single_active", 32'(bus.o_active), 32'h1);
      bus.i_req     = '0;
      bus.i_tx_busy = 1'b1;
      tick();
      check("single_gnt_pulse",   32'(bus.o_gnt), 32'h0);
      check("single_valid_pulse", 32'(bus.o_tx_data_valid), 32'h0);
      bad = 0;
      for (int c = 0; c < 9; c++) begin
         if (bus.o_tx_data !== 8'hA5 || bus.o_active !== 1'b1) bad++;
         tick();
      end
      if (bus.o_tx_data !== 8'hA5 || bus.o_active !== 1'b1) bad++;
      check("single_hold", 32'(bad), 32'h0);
      bus.i_tx_busy = 1'b0;
      tick();
      check("single_idle", 32'(bus.o_active), 32'h0);

      // Fairness: all four requesting continuously after reset
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) set_byte(k, 8'(8'h10 + k));
      bus.i_req = 4'b1111;
      for (int n = 0; n < 8; n++) begin
         wait_gnt($sformatf("fair%0d", n), g);
         check($sformatf("fair%0d_gnt", n),   32'(g), 32'(1 << (n % 4)));
         check($sformatf("fair%0d_owner", n), 32'(bus.o_owner), 32'(n % 4));
         check($sformatf("fair%0d_data", n),  32'(bus.o_tx_data), 32'(8'h10 + n % 4));
         busy_cycle();
      end
      bus.i_req = '0;

      // Busy timeout: requester 1 granted, busy never rises
      tick();
      bus.i_req = 4'b0010;
      tick();
      check("to_gnt", 32'(bus.o_gnt), 32'h2);
      bus.i_req = '0;
      bad = 0;
      for (int c = 0; c < BUSY_TO - 1; c++) begin
         tick();
         if (bus.o_err !== 1'b0 || bus.o_active !== 1'b1) bad++;
      end
      check("to_early", 32'(bad), 32'h0);
      tick();
      check("to_err",  32'(bus.o_err), 32'h1);
      check("to_idle", 32'(bus.o_active), 32'h0);
      bus.i_req = 4'b1111;
      tick();
      check("to_err_pulse", 32'(bus.o_err), 32'h0);
      check("to_next_gnt",  32'(bus.o_gnt), 32'h4);
      check("to_next_own",  32'(bus.o_owner), 32'h2);
      bus.i_req = '0;
      busy_cycle();

      // Busy guard: request ignored while the transmitter is busy in IDLE
      bus.i_tx_busy = 1'b1;
      set_byte(0, 8'h5A);
      bus.i_req = 4'b0001;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (bus.o_gnt !== 4'b0000) bad++;
      end
      check("guard_hold", 32'(bad), 32'h0);
      bus.i_tx_busy = 1'b0;
      tick();
      check("guard_gnt",  32'(bus.o_gnt), 32'h1);
      check("guard_data", 32'(bus.o_tx_data), 32'h5A);
      bus.i_req = '0;
      busy_cycle();

      // Reset during WAIT_DONE
      set_byte(1, 8'h3C);
      bus.i_req = 4'b0010;
      tick();
      check("rst_pre_gnt", 32'(bus.o_gnt), 32'h2);
      bus.i_req     = '0;
      bus.i_tx_busy = 1'b1;
      tick();
      check("rst_pre_active", 32'(bus.o_active), 32'h1);
      #2 rst = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus.o_gnt !== 4'b0000) bad++;
      end
      check("rst_hold", 32'(bad), 32'h0);
      bus.i_tx_busy = 1'b0;
      rst = 1'b1;
      set_byte(3, 8'hC3);
      bus.i_req = 4'b1000;
      tick();
      check("rst_post_gnt",   32'(bus.o_gnt), 32'h8);
      check("rst_post_owner", 32'(bus.o_owner), 32'h3);
      check("rst_post_data",  32'(bus.o_tx_data), 32'hC3);
      bus.i_req = '0;
      busy_cycle();

`ifdef UART_TX_ARB_LOCK_EN
      // Packet lock: requester 1 sends three bytes, requester 0 waits
      rst = 1'b0;
      tick();
      rst = 1'b1;
      set_byte(0, 8'h01);
      set_byte(1, 8'hB0);
      bus.i_last = 4'b0000;
      bus.i_req  = 4'b0010;
      tick();
      check("lock_g0", 32'(bus.o_gnt), 32'h2);
      bus.i_req = 4'b0011;
      set_byte(1, 8'hB1);
      busy_cycle();
      wait_gnt("lock_w1", g);
      check("lock_g1", 32'(g), 32'h2);
      check("lock_d1", 32'(bus.o_tx_data), 32'hB1);
      set_byte(1, 8'hB2);
      bus.i_last = 4'b0010;
      busy_cycle();
      wait_gnt("lock_w2", g);
      check("lock_g2", 32'(g), 32'h2);
      bus.i_req  = 4'b0001;
      bus.i_last = 4'b0000;
      busy_cycle();
      wait_gnt("lock_w3", g);
      check("lock_g3", 32'(g), 32'h1);
      bus.i_req = '0;
      busy_cycle();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
- REQ-001: Parameters SHALL be:
  - NUM_REQ, default 4, number of requesters (2..8).
  - WIDTH, default 8, data byte width.
  - BUSY_TO, default 4, cycles to wait for transmitter busy after launch.
- REQ-002: Ports SHALL be:
  - i_clk  in  1  sole clock, rising edge.
  - i_rst  in  1  asynchronous, active-low reset.
  - i_req  in  NUM_REQ  per-requester byte request.
  - i_data  in  NUM_REQ*WIDTH  flattened bytes; requester k occupies [k*WIDTH +: WIDTH].
  - i_last  in  NUM_REQ  last byte of a packet; used only under the lock macro.
  - o_gnt  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester k captured.
  - o_owner  out  clog2(NUM_REQ)  index of the most recent grant.
  - o_tx_data_valid  out  1  launch pulse to the UART TX data_valid input.
  - o_tx_data  out  WIDTH  byte to the UART TX data input.
  - i_tx_busy  in  1  UART TX busy flag.
  - o_active  out  1  high whenever state is not IDLE.
  - o_err  out  1  one-cycle pulse on busy timeout.

Function
- REQ-003: The FSM SHALL have exactly three states: IDLE, WAIT_BUSY, WAIT_DONE.
- REQ-004: In IDLE with i_tx_busy=0 and any eligible i_req bit set at edge k:
  - pick the winner round-robin, searching from last owner+1 with wraparound;
  - register o_tx_data, o_owner, o_gnt, o_tx_data_valid=1;
  - go to WAIT_BUSY.
  - All registered outputs SHALL be visible in cycle k+1 (latency 1).
- REQ-005: In IDLE, i_req SHALL be ignored while i_tx_busy=1.
- REQ-006: o_gnt and o_tx_data_valid SHALL each be high for exactly one cycle per grant.
- REQ-007: o_tx_data SHALL hold constant from launch until the return to IDLE, because the transmitter computes parity combinationally from its data input.
- REQ-008: WAIT_BUSY SHALL go to WAIT_DONE on i_tx_busy=1.
- REQ-009: If i_tx_busy is not seen high within BUSY_TO cycles of entering WAIT_BUSY, the FSM SHALL go to IDLE and pulse o_err.
- REQ-010: WAIT_DONE SHALL go to IDLE on i_tx_busy=0. Back-to-back grants are therefore separated by at least one IDLE cycle.
- REQ-011: Requester handshake:
  - a requester holds i_req and its byte until it sees its o_gnt;
  - withdrawing i_req before grant is legal and SHALL produce no grant;
  - a new byte may be presented the cycle after o_gnt.
- REQ-012: Simultaneous requests SHALL be resolved strictly round-robin. With all NUM_REQ requesting continuously, each SHALL be granted once per NUM_REQ grants.
- REQ-013: Round-robin pointer handling:
  - the pointer SHALL update only on a grant;
  - a timeout SHALL NOT advance it beyond the granted index.

Reset
- REQ-014: While i_rst=0, asynchronously:
  - state=IDLE;
  - o_gnt=0, o_tx_data_valid=0, o_tx_data=0, o_owner=0, o_active=0, o_err=0;
  - round-robin pointer=NUM_REQ-1, so requester 0 has first priority;
  - lock cleared.
- REQ-015: Reset mid-frame SHALL abandon the byte without a further o_gnt. No state SHALL survive reset.

Configuration
- REQ-016: With UART_TX_ARB_LOCK_EN defined:
  - a grant whose i_last bit was 0 SHALL set a lock on that owner;
  - while locked, only that owner SHALL be eligible, and the arbiter waits indefinitely for its i_req;
  - a grant with i_last=1 SHALL release the lock.
- REQ-017: Without UART_TX_ARB_LOCK_EN, i_last SHALL be ignored, no lock register SHALL exist, and every byte SHALL be arbitrated independently.

Structure
- REQ-018: A shared package uart_pkg SHALL hold WIDTH, the default NUM_REQ, and the FSM state encoding.
- REQ-019: The round-robin search SHALL be one combinational sub-module, uart_rr_picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any-valid.

Verification
- REQ-020: Single request: i_req=4'b0100, data 8'hA5, busy rises 1 cycle after launch and falls 10 cycles later -> at k+1 o_gnt=4'b0100, o_tx_data=8'hA5, o_tx_data_valid=1 for 1 cycle, o_owner=2; o_tx_data stable until IDLE.
- REQ-021: Fairness: i_req=4'b1111 held for 8 grants after reset -> grant order 0,1,2,3,0,1,2,3.
- REQ-022: Timeout: grant issued, i_tx_busy held 0 -> o_err pulses after BUSY_TO=4 cycles, FSM in IDLE, next grant goes to the following index.
- REQ-023: Busy guard: i_tx_busy=1 in IDLE with i_req=4'b0001 -> no o_gnt until busy falls, then o_gnt=4'b0001 one cycle later.
- REQ-024: Reset mid-frame: i_rst=0 during WAIT_DONE -> all outputs 0 immediately; after release with i_req=4'b1000 -> grant to 3, pointer started from 0.
- REQ-025: Lock (macro on): requester 1 sends 3 bytes with i_last=0,0,1 while requester 0 requests continuously -> grants 1,1,1,0.
